keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans the 4x4 active-low key matrix, debounces it and produces a clean key code with a level-valid flag and single-cycle press/release strobes. It sits directly upstream of the game module. key_code drives the game's keypad_input, and key_press drives its keypad_enable, so the game sees exactly one enable pulse per physical press. Game notes occupy codes 1–8. The remaining codes are passed through, and the consumer ignores them.

## Interface
- SCAN_DIV, default 12500: clk cycles each column is driven; minimum 2.
- DEBOUNCE_SCANS, default 20: consecutive identical full scans required to accept a change; minimum 1.
- clk  in  1  system clock (50 MHz).
- reset  in  1  reset, asynchronous, active-high.
- row_in  in  4  matrix rows, active-low, externally pulled up, asynchronous to clk.
- col_out  out  4  column drive, active-low one-hot.
- key_code  out  4  debounced key code = {row[1:0], col[1:0]}; holds last value after release.
- key_valid  out  1  high while a debounced key is held.
- key_press  out  1  one-cycle strobe when a key becomes debounced-pressed.
- key_release  out  1  one-cycle strobe when the debounced key is released.

## Operation
- row_in passes through a 2-FF synchronizer; all sampling uses the synchronized value.
- Scan counter:
  - div_cnt counts 0..SCAN_DIV-1 and wraps.
  - col_idx (0..3) advances when div_cnt = SCAN_DIV-1, wrapping 3→0.
  - col_out = ~(1 << col_idx).
- Sampling: on the div_cnt = SCAN_DIV-1 edge, the synchronized rows for the current col_idx are captured into a 16-bit scan accumulator.
- Scan completion: on the col_idx = 3 sample edge, the scan is classified into raw result NONE, SINGLE(code) or MULTI (two or more keys asserted). scan_done is high on the following cycle.
- Debounce, evaluated on the scan_done cycle:
  - MULTI: stable_cnt ← 0 and prev_raw ← MULTI. Debounced state is unchanged, so a multi-key chord never presses or releases anything.
  - Raw equals prev_raw (not MULTI): stable_cnt ← min(stable_cnt+1, DEBOUNCE_SCANS).
  - Otherwise: prev_raw ← raw and stable_cnt ← 1.
  - Acceptance occurs when the updated stable_cnt equals DEBOUNCE_SCANS and prev_raw differs from the debounced state.
- Output FSM states: IDLE, HELD, SWITCH.
  - IDLE + accepted SINGLE(k): key_code ← k, key_valid ← 1, key_press pulse → HELD.
  - HELD + accepted NONE: key_valid ← 0, key_release pulse, key_code retained → IDLE.
  - HELD + accepted SINGLE(k') with k' ≠ key code: key_valid ← 0, key_release pulse → SWITCH. In SWITCH, on the next cycle unconditionally: key_code ← k', key_valid ← 1, key_press pulse → HELD.
  - key_press and key_release are never high in the same cycle.
- Reset, effective immediately and asynchronously:
  - col_out = 4'b1110; key_code = 0; key_valid = 0; key_press = 0; key_release = 0.
  - div_cnt = 0, col_idx = 0, stable_cnt = 0, prev_raw = NONE, FSM = IDLE.
  - A key held across reset is reported again only after a full DEBOUNCE_SCANS acceptance. No release strobe is emitted for a key that was held when reset asserted.

## Timing
- Scan period: 4·SCAN_DIV cycles. Defaults give 1 ms per scan and 20 ms debounce.
- Row settling: each column is driven for SCAN_DIV-1 cycles before its sample. Synchronizer latency is 2 cycles.
- Press latency: from the first scan that sees the key (key stable at least 2 cycles before each of its sample edges), outputs update on the edge after the scan_done of scan number DEBOUNCE_SCANS. Worst case is (DEBOUNCE_SCANS+1)·4·SCAN_DIV + 4 cycles.
- Strobes are exactly one clk cycle wide. key_code is stable on and after the cycle key_press is high.
- Bounce: any scan differing from prev_raw restarts the count at 1, so glitches shorter than one scan period, but spanning a sample, delay acceptance rather than causing double strobes.
- Saturation: stable_cnt holds at DEBOUNCE_SCANS while the input is steady. No repeat strobes are generated.

## Test plan
Test parameters: SCAN_DIV=4, DEBOUNCE_SCANS=3.
- Reset check: assert reset mid-scan with key 5 held → col_out=1110, key_valid=0 and no strobes during reset. After release, key_press occurs with key_code=5 after 3 full scans.
- Clean press/release: hold row1,col2 (code 6) from scan start → col_out cycles 1110,1101,1011,0111 every 4 cycles; key_press with key_code=6 one cycle after the 3rd scan_done. After release, key_release 3 scans later, key_valid=0 and key_code stays 6.
- Bounce: toggle code 3 every other scan for 5 scans, then hold → exactly one key_press, occurring 3 scans after the hold begins.
- Chord: hold codes 1 and 2 together for 10 scans → no strobes and key_valid=0. Then release code 2 → key_press with key_code=1 after 3 scans.
- Switch: hold code 4 (accepted), then move directly to code 8 → key_release and key_valid=0 on one cycle; next cycle key_press, key_code=8, key_valid=1.
- Long hold: hold code 7 for 50 scans → exactly one key_press and no further strobes; stable count saturates.

Source files
------------

// File: rtl/keypad_if.sv
// rtl/keypad_if.sv - keypad matrix and debounced key event signals
interface keypad_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_press;
  logic       key_release;

  modport master (
    input  row_in,
    output col_out, key_code, key_valid, key_press, key_release
  );

  modport slave (
    output row_in,
    input  col_out, key_code, key_valid, key_press, key_release
  );
endinterface

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 active-low keypad scanner with scan-based debounce
// and one-cycle press/release strobes.
module keypad_scanner #(
  parameter int SCAN_DIV       = 12500,
  parameter int DEBOUNCE_SCANS = 20
) (
  input  logic     clk,
  input  logic     reset,
  keypad_if.master kp
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {RAW_NONE, RAW_SINGLE, RAW_MULTI} raw_kind_t;
  typedef enum logic [1:0] {IDLE, HELD, SWITCH} state_t;

  logic [3:0]       row_meta, row_sync;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       col_idx;
  logic [15:0]      scan_acc, acc_next;
  logic             scan_done;
  raw_kind_t        raw_kind, cls_kind;
  logic [3:0]       raw_code, cls_code;
  logic [4:0]       n_keys;

  raw_kind_t        prev_kind, nxt_prev_kind;
  logic [3:0]       prev_code, nxt_prev_code;
  logic [CNT_W-1:0] stable_cnt, nxt_cnt;
  logic             differs, accept;

  state_t           state;
  logic [3:0]       key_code_q, pend_code;
  logic             key_valid_q, key_press_q, key_release_q;

  wire sample_tick = (div_cnt == DIV_LAST);

  assign kp.col_out     = ~(4'b0001 << col_idx);
  assign kp.key_code    = key_code_q;
  assign kp.key_valid   = key_valid_q;
  assign kp.key_press   = key_press_q;
  assign kp.key_release = key_release_q;

  // Bit {row, col} of the accumulator is set when that key reads as pressed.
  always_comb begin
    acc_next = scan_acc;
    for (int r = 0; r < 4; r++) begin
      acc_next[{2'(r), col_idx}] = ~row_sync[r];
    end
  end

  always_comb begin
    n_keys   = '0;
    cls_code = '0;
    for (int i = 0; i < 16; i++) begin
      if (acc_next[i]) begin
        n_keys   = n_keys + 5'd1;
        cls_code = 4'(i);
      end
    end
    if (n_keys == 5'd0)      cls_kind = RAW_NONE;
    else if (n_keys == 5'd1) cls_kind = RAW_SINGLE;
    else                     cls_kind = RAW_MULTI;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_meta  <= 4'hF;
      row_sync  <= 4'hF;
      div_cnt   <= '0;
      col_idx   <= 2'd0;
      scan_acc  <= '0;
      scan_done <= 1'b0;
      raw_kind  <= RAW_NONE;
      raw_code  <= 4'd0;
    end else begin
      row_meta  <= kp.row_in;
      row_sync  <= row_meta;
      scan_done <= 1'b0;
      if (sample_tick) begin
        div_cnt  <= '0;
        col_idx  <= col_idx + 2'd1;
        scan_acc <= acc_next;
        if (col_idx == 2'd3) begin
          scan_done <= 1'b1;
          raw_kind  <= cls_kind;
          raw_code  <= cls_code;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // A chord resets the count and poisons prev so it can never be accepted.
  always_comb begin
    nxt_prev_kind = prev_kind;
    nxt_prev_code = prev_code;
    nxt_cnt       = stable_cnt;
    if (raw_kind == RAW_MULTI) begin
      nxt_prev_kind = RAW_MULTI;
      nxt_cnt       = '0;
    end else if (raw_kind == prev_kind &&
                 (raw_kind == RAW_NONE || raw_code == prev_code)) begin
      nxt_cnt = (stable_cnt == CNT_MAX) ? CNT_MAX : stable_cnt + 1'b1;
    end else begin
      nxt_prev_kind = raw_kind;
      nxt_prev_code = raw_code;
      nxt_cnt       = CNT_W'(1);
    end

    case (nxt_prev_kind)
      RAW_NONE:   differs = (state == HELD);
      RAW_SINGLE: differs = (state != HELD) || (nxt_prev_code != key_code_q);
      default:    differs = 1'b0;
    endcase
    accept = scan_done && (nxt_cnt == CNT_MAX) && differs;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_cnt    <= '0;
      prev_kind     <= RAW_NONE;
      prev_code     <= 4'd0;
      state         <= IDLE;
      key_code_q    <= 4'd0;
      pend_code     <= 4'd0;
      key_valid_q   <= 1'b0;
      key_press_q   <= 1'b0;
      key_release_q <= 1'b0;
    end else begin
      key_press_q   <= 1'b0;
      key_release_q <= 1'b0;
      if (scan_done) begin
        stable_cnt <= nxt_cnt;
        prev_kind  <= nxt_prev_kind;
        prev_code  <= nxt_prev_code;
      end
      case (state)
        IDLE: begin
          if (accept && nxt_prev_kind == RAW_SINGLE) begin
            key_code_q  <= nxt_prev_code;
            key_valid_q <= 1'b1;
            key_press_q <= 1'b1;
            state       <= HELD;
          end
        end
        HELD: begin
          if (accept) begin
            key_valid_q   <= 1'b0;
            key_release_q <= 1'b1;
            if (nxt_prev_kind == RAW_SINGLE) begin
              pend_code <= nxt_prev_code;
              state     <= SWITCH;
            end else begin
              state <= IDLE;
            end
          end
        end
        SWITCH: begin
          // Separates the release and press strobes of a direct key change.
          key_code_q  <= pend_code;
          key_valid_q <= 1'b1;
          key_press_q <= 1'b1;
          state       <= HELD;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed bench for keypad_scanner with a key matrix model
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] held = '0;
  logic [3:0]  row_model;
  int          rel_cyc;
  int          checks = 0, failures = 0;
  int          press_cnt = 0, release_cnt = 0, press_cyc = -1, release_cyc = -1;
  int          press_code = -1;
  int          both_seen = 0;

  keypad_if kp ();

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kp)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_model = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (held[r*4 + c] && !kp.col_out[c]) row_model[r] = 1'b0;
  end
  assign kp.row_in = row_model;

  always @(posedge clk or posedge reset) begin
    if (reset) rel_cyc <= 0;
    else       rel_cyc <= rel_cyc + 1;
  end

  always @(negedge clk) begin
    if (kp.key_press) begin
      press_cnt  = press_cnt + 1;
      press_cyc  = rel_cyc;
      press_code = int'(kp.key_code);
    end
    if (kp.key_release) begin
      release_cnt = release_cnt + 1;
      release_cyc = rel_cyc;
    end
    if (kp.key_press && kp.key_release) both_seen = 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    press_cnt = 0; release_cnt = 0; press_cyc = -1; release_cyc = -1; press_code = -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    clear_counts();
    reset = 1'b0;
  endtask

  task automatic wait_rel(input int n);
    int guard = 0;
    while (rel_cyc < n) begin
      @(negedge clk);
      #1;
      guard++;
      if (guard > 5000) begin
        check("wait_timeout", rel_cyc, n);
        return;
      end
    end
  endtask

  initial begin
    // Reset behaviour with key 5 held before and across a mid-scan reset
    held = 16'h1 << 5;
    do_reset();
    wait_rel(50);
    check("t1_first_press_cnt", press_cnt, 1);
    check("t1_first_press_code", press_code, 5);
    wait_rel(58);
    clear_counts();
    #2 reset = 1'b1;
    #1;
    check("t1_rst_col_out", kp.col_out, 4'b1110);
    check("t1_rst_valid", kp.key_valid, 0);
    check("t1_rst_code", kp.key_code, 0);
    check("t1_rst_press", kp.key_press, 0);
    repeat (4) @(negedge clk);
    check("t1_rst_strobes", press_cnt + release_cnt, 0);
    reset = 1'b0;
    wait_rel(60);
    check("t1_press_cnt", press_cnt, 1);
    check("t1_press_cyc", press_cyc, 49);
    check("t1_press_code", press_code, 5);
    check("t1_no_release", release_cnt, 0);

    // Clean press and release of code 6
    held = 16'h1 << 6;
    do_reset();
    wait_rel(1);  check("t2_col_1", kp.col_out, 4'b1110);
    wait_rel(4);  check("t2_col_4", kp.col_out, 4'b1101);
    wait_rel(8);  check("t2_col_8", kp.col_out, 4'b1011);
    wait_rel(12); check("t2_col_12", kp.col_out, 4'b0111);
    wait_rel(16); check("t2_col_16", kp.col_out, 4'b1110);
    wait_rel(48); check("t2_valid_before", kp.key_valid, 0);
    wait_rel(50);
    check("t2_press_cnt", press_cnt, 1);
    check("t2_press_cyc", press_cyc, 49);
    check("t2_press_code", press_code, 6);
    check("t2_valid_held", kp.key_valid, 1);
    held = '0;
    wait_rel(100);
    check("t2_release_cnt", release_cnt, 1);
    check("t2_release_cyc", release_cyc, 97);
    check("t2_valid_after", kp.key_valid, 0);
    check("t2_code_kept", kp.key_code, 6);
    check("t2_press_once", press_cnt, 1);

    // Bounce: code 3 alternating per scan for 5 scans, then held
    held = '0;
    do_reset();
    for (int n = 1; n <= 5; n++) begin
      wait_rel(16 * (n - 1));
      held = (n % 2 == 0) ? (16'h1 << 3) : 16'h0;
    end
    wait_rel(80);
    held = 16'h1 << 3;
    wait_rel(200);
    check("t3_press_cnt", press_cnt, 1);
    check("t3_press_cyc", press_cyc, 129);
    check("t3_press_code", press_code, 3);
    check("t3_no_release", release_cnt, 0);

    // Chord of codes 1 and 2, then release code 2
    held = (16'h1 << 1) | (16'h1 << 2);
    do_reset();
    wait_rel(160);
    check("t4_chord_press", press_cnt, 0);
    check("t4_chord_release", release_cnt, 0);
    check("t4_chord_valid", kp.key_valid, 0);
    held = 16'h1 << 1;
    wait_rel(215);
    check("t4_press_cnt", press_cnt, 1);
    check("t4_press_cyc", press_cyc, 209);
    check("t4_press_code", press_code, 1);

    // Direct switch from code 4 to code 8
    held = 16'h1 << 4;
    do_reset();
    wait_rel(49);
    check("t5_first_press", press_cnt, 1);
    held = 16'h1 << 8;
    wait_rel(97);
    check("t5_release", kp.key_release, 1);
    check("t5_rel_valid", kp.key_valid, 0);
    check("t5_rel_nopress", kp.key_press, 0);
    check("t5_rel_code", kp.key_code, 4);
    wait_rel(98);
    check("t5_press", kp.key_press, 1);
    check("t5_press_code", kp.key_code, 8);
    check("t5_press_valid", kp.key_valid, 1);
    check("t5_press_norel", kp.key_release, 0);

    // Long hold of code 7 for 50 scans
    held = 16'h1 << 7;
    do_reset();
    wait_rel(16 * 50 + 4);
    check("t6_press_cnt", press_cnt, 1);
    check("t6_press_cyc", press_cyc, 49);
    check("t6_press_code", press_code, 7);
    check("t6_no_release", release_cnt, 0);
    check("t6_stable_sat", 32'(dut.stable_cnt), 3);

    check("both_strobes_seen", both_seen, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
